// File: rtl/tile_ram_arbiter_pkg.sv
// Shared constants and state encoding for the tile RAM arbiter and the VGA timing block.
package tile_ram_arbiter_pkg;

  localparam int HMAX   = 800;
  localparam int VMAX   = 525;
  localparam int HLINES = 640;
  localparam int VLINES = 480;

  localparam int TILE_W = 4;

  typedef enum logic [1:0] {
    RENDER = 2'd0,
    TICK   = 2'd1,
    SERVE  = 2'd2
  } state_e;

endpackage

// File: rtl/tile_ram_arbiter_tile_index_calc.sv
// Combinational tile index: row * COLS + col.
module tile_ram_arbiter_tile_index_calc #(
  parameter int COLS = 40
) (
  input  logic [10:0] row_i,
  input  logic [10:0] col_i,
  output logic [10:0] index_o
);

  generate
    if (COLS == 40) begin : g_x40
      // 40 = 32 + 8, so the multiply reduces to two shifts and an add
      assign index_o = (row_i << 5) + (row_i << 3) + col_i;
    end else begin : g_mul
      assign index_o = (row_i * 11'(COLS)) + col_i;
    end
  endgenerate

endmodule

// File: rtl/tile_ram_arbiter.sv
// Shares the tile RAM port between the renderer (active video) and two
// round-robin writers (vertical blanking window), sequenced by hcount/vcount.
module tile_ram_arbiter
  import tile_ram_arbiter_pkg::*;
#(
  parameter int HMAX       = tile_ram_arbiter_pkg::HMAX,
  parameter int VMAX       = tile_ram_arbiter_pkg::VMAX,
  parameter int HLINES     = tile_ram_arbiter_pkg::HLINES,
  parameter int VLINES     = tile_ram_arbiter_pkg::VLINES,
  parameter int TILE_SHIFT = 4,
  parameter int COLS       = 40,
  parameter int GUARD      = 2
) (
  input  logic              VGA_clock,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  input  logic [1:0]        req,
  input  logic [10:0]       wr_addr0,
  input  logic [10:0]       wr_addr1,
  input  logic [TILE_W-1:0] wr_data0,
  input  logic [TILE_W-1:0] wr_data1,
  output logic [1:0]        gnt,
  output logic [10:0]       ram_addr,
  output logic [TILE_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              frame_tick,
  output logic              window
);

  localparam logic [10:0] H_LINES = 11'(HLINES);
  localparam logic [10:0] V_LINES = 11'(VLINES);
  localparam logic [10:0] V_MAX   = 11'(VMAX);
  localparam logic [10:0] H_CLOSE = 11'(HMAX - GUARD);

  state_e            state_q, state_d;
  logic              last_q;
  logic [10:0]       ram_addr_q;
  logic [TILE_W-1:0] ram_wdata_q;
  logic              ram_we_q;
  logic              frame_tick_q;
  logic              window_q;

  logic [1:0]        gnt_c;
  logic              xfer_c;
  logic              active_c;
  logic              open_c;
  logic              close_c;
  logic [10:0]       tile_idx;

  assign active_c = (hcount < H_LINES) && (vcount < V_LINES);
  assign open_c   = (vcount == V_LINES) && (hcount == 11'd0);
  assign close_c  = (vcount == V_MAX) && (hcount == H_CLOSE);

  tile_ram_arbiter_tile_index_calc #(
    .COLS (COLS)
  ) u_tile_index_calc (
    .row_i   (vcount >> TILE_SHIFT),
    .col_i   (hcount >> TILE_SHIFT),
    .index_o (tile_idx)
  );

  // Grants are withheld on the closing cycle so no write races the state change
  always_comb begin
    gnt_c = 2'b00;
    if (!reset && (state_q == SERVE) && !close_c) begin
      case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
        default: gnt_c = 2'b00;
      endcase
    end
  end

  assign xfer_c = |(req & gnt_c);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RENDER:  if (open_c) state_d = TICK;
      TICK:    state_d = SERVE;
      SERVE:   if (close_c) state_d = RENDER;
      default: state_d = RENDER;
    endcase
  end

  always_ff @(posedge VGA_clock or posedge reset) begin
    if (reset) begin
      state_q <= RENDER;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (xfer_c) last_q <= gnt_c[1];
    end
  end

  always_ff @(posedge VGA_clock or posedge reset) begin
    if (reset) begin
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      window_q     <= 1'b0;
    end else begin
      ram_we_q     <= xfer_c;
      frame_tick_q <= (state_d == TICK);
      window_q     <= (state_d == SERVE);
      if (xfer_c) begin
        ram_addr_q  <= gnt_c[0] ? wr_addr0 : wr_addr1;
        ram_wdata_q <= gnt_c[0] ? wr_data0 : wr_data1;
      end else if ((state_q == RENDER) && active_c) begin
        ram_addr_q <= tile_idx;
      end
    end
  end

  assign gnt        = gnt_c;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign frame_tick = frame_tick_q;
  assign window     = window_q;

endmodule
